parking_time_stamper: RTL
=========================

// Module: parking_time_stamper
// PURPOSE
//  Timestamp source for the parking billing path. Runs a prescaled free-running
//  8-bit parking clock, records each slot's entry time, and on car exit emits a
//  {time_in, time_out} pair over a valid/ready channel. The pair feeds the
//  time_calculate stage, which computes time_out - time_in modulo 256.
// PARAMETERS
//  SLOTS    8  number of parking slots tracked
//  SLOT_W   3  width of slot_id; must satisfy 2**SLOT_W >= SLOTS
//  TICK_DIV 4  clk cycles per parking time unit; must be >= 1
//  TIME_W   8  timestamp width; fixed at 8 to match time_calculate
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  enter      in   1       car-entry event for slot_id (1-cycle strobe)
//  exit       in   1       car-exit event for slot_id (1-cycle strobe)
//  slot_id    in   SLOT_W  slot addressed by enter/exit
//  occupied   out  SLOTS   per-slot occupancy flags
//  time_now   out  TIME_W  current parking clock
//  time_in    out  TIME_W  entry timestamp of the exiting car
//  time_out   out  TIME_W  exit timestamp of the exiting car
//  out_valid  out  1       time_in/time_out pair valid
//  out_ready  in   1       consumer accepts the pair
//  err        out  1       1-cycle pulse: rejected event
// BEHAVIOUR
//  Reset (clk edge with reset=1)
//  - prescaler=0, time_now=0, occupied=0, all entry regs=0.
//  - time_in=0, time_out=0, out_valid=0, err=0. Output FSM=IDLE.
//  - Reset mid-operation drops a pending pair and all occupancy.
//  Clock
//  - prescaler counts 0..TICK_DIV-1.
//  - time_now increments on the cycle the prescaler equals TICK_DIV-1.
//  - time_now wraps 255->0 with no flag. Wrap is legal: the consumer subtracts mod 256.
//  Events (sampled every clk; all updates registered, 1-cycle latency)
//  - enter and exit both high: err=1; neither event is applied.
//  - enter on a free slot: entry[slot]<=time_now (pre-increment value); occupied[slot]<=1.
//  - enter on an occupied slot, or slot_id>=SLOTS: err=1; no state change.
//  - exit on an occupied slot while the channel can load: time_in<=entry[slot],
//    time_out<=time_now, out_valid<=1, occupied[slot]<=0.
//  - exit on a free slot or slot_id>=SLOTS: err=1.
//  - exit while the channel is blocked (FULL and !out_ready): err=1; slot stays
//    occupied so the event can be retried.
//  - err otherwise 0.
//  Output FSM (IDLE/FULL)
//  - IDLE: an accepted exit loads the pair -> FULL.
//  - FULL: time_in/time_out/out_valid held stable until out_ready=1.
//  - FULL, out_ready=1, no exit: -> IDLE, out_valid<=0.
//  - FULL, out_ready=1, accepted exit the same cycle: load the new pair, stay FULL
//    (back-to-back with no bubble).
//  - Channel can load = IDLE, or FULL with out_ready=1.
//  - out_ready is ignored in IDLE.
// TESTING (TICK_DIV=4)
//  1 Reset, then 40 idle cycles -> time_now=10, occupied=0, out_valid=0, err=0.
//  2 enter slot 2 at time_now=1; exit slot 2 at time_now=15, out_ready=1 ->
//    next cycle time_in=1, time_out=15, out_valid=1, occupied[2]=0.
//  3 enter slot 5 at time_now=250; exit after wrap at time_now=4 -> time_in=250,
//    time_out=4 (downstream 8-bit diff=10).
//  4 Hold out_ready=0 with a pair pending; exit slot 1 (occupied) -> err=1,
//    pair unchanged, occupied[1]=1. Raise out_ready with a retry of that exit
//    -> new pair loaded, out_valid stays 1.
//  5 enter an occupied slot; exit a free slot; enter+exit together -> err=1
//    each time, occupied unchanged.
//  6 Assert reset while FULL with 3 slots occupied -> next cycle out_valid=0,
//    occupied=0, time_now=0.

Source files
------------

// File: rtl/parking_time_stamper_if.sv
// Event and timestamp channel for parking_time_stamper.
// The master side issues slot events and accepts pairs; the slave side is the stamper.
interface parking_time_stamper_if #(
  parameter int SLOTS  = 8,
  parameter int SLOT_W = 3,
  parameter int TIME_W = 8
);
  logic              enter;
  logic              exit;
  logic [SLOT_W-1:0] slot_id;
  logic [SLOTS-1:0]  occupied;
  logic [TIME_W-1:0] time_now;
  logic [TIME_W-1:0] time_in;
  logic [TIME_W-1:0] time_out;
  logic              out_valid;
  logic              out_ready;
  logic              err;

  modport master (
    output enter, exit, slot_id, out_ready,
    input  occupied, time_now, time_in, time_out, out_valid, err
  );

  modport slave (
    input  enter, exit, slot_id, out_ready,
    output occupied, time_now, time_in, time_out, out_valid, err
  );
endinterface

// File: rtl/parking_time_stamper.sv
// Prescaled 8-bit parking clock with per-slot entry timestamps.
// Each accepted exit emits a {time_in, time_out} pair on a valid/ready channel.
module parking_time_stamper #(
  parameter int SLOTS    = 8,
  parameter int SLOT_W   = 3,
  parameter int TICK_DIV = 4,
  parameter int TIME_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  parking_time_stamper_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [PRE_W-1:0]  pre_q,   pre_d;
  logic [TIME_W-1:0] time_q,  time_d;
  logic [SLOTS-1:0]  occ_q,   occ_d;
  logic [TIME_W-1:0] entry_q [SLOTS];
  logic [TIME_W-1:0] entry_d [SLOTS];
  logic [TIME_W-1:0] tin_q,   tin_d;
  logic [TIME_W-1:0] tout_q,  tout_d;
  logic [0:0]        state_q, state_d;
  logic              err_q,   err_d;

  logic slot_ok, slot_busy, can_load, enter_ok, exit_ok;

  // NOTE: every variable written below gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pre_d   = pre_q;
    time_d  = time_q;
    occ_d   = occ_q;
    entry_d = entry_q;
    tin_d   = tin_q;
    tout_d  = tout_q;
    state_d = state_q;

    if (pre_q == PRE_W'(TICK_DIV - 1)) begin
      pre_d  = '0;
      time_d = time_q + 1'b1;
    end else begin
      pre_d  = pre_q + 1'b1;
    end

    slot_ok   = 32'(bus.slot_id) < SLOTS;
    slot_busy = slot_ok && occ_q[bus.slot_id];
    can_load  = (state_q == ST_IDLE) || bus.out_ready;

    // Simultaneous enter and exit is ambiguous, so neither one is applied.
    enter_ok = bus.enter && !bus.exit && slot_ok && !slot_busy;
    exit_ok  = bus.exit && !bus.enter && slot_busy && can_load;
    err_d    = (bus.enter || bus.exit) && !enter_ok && !exit_ok;

    if (enter_ok) begin
      entry_d[bus.slot_id] = time_q;
      occ_d[bus.slot_id]   = 1'b1;
    end

    if (exit_ok) begin
      tin_d              = entry_q[bus.slot_id];
      tout_d             = time_q;
      occ_d[bus.slot_id] = 1'b0;
      state_d            = ST_FULL;
    end else if (state_q == ST_FULL && bus.out_ready) begin
      state_d = ST_IDLE;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      time_q  <= '0;
      occ_q   <= '0;
      tin_q   <= '0;
      tout_q  <= '0;
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      // NOTE: the entry table is small and must read back as zero after reset, so it is cleared explicitly.
      for (int i = 0; i < SLOTS; i++) entry_q[i] <= '0;
    end else begin
      pre_q   <= pre_d;
      time_q  <= time_d;
      occ_q   <= occ_d;
      entry_q <= entry_d;
      tin_q   <= tin_d;
      tout_q  <= tout_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign bus.occupied  = occ_q;
  assign bus.time_now  = time_q;
  assign bus.time_in   = tin_q;
  assign bus.time_out  = tout_q;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.err       = err_q;

endmodule
